seq_left_shifter: RTL and testbench

Multi-cycle left shifter for the ALU datapath, the left-direction counterpart of the combinational right shifter. It shifts `A` left by `B` positions one bit per clock, filling vacated LSBs with `shift_bit`. Shift amounts of `WIDTH` or more saturate to a full flush. A start/busy/done handshake lets the control unit issue shifts without a wide barrel network.

---
 rtl/seq_left_shifter.sv | 79 +++++++
 tb/tb_seq_left_shifter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_left_shifter.sv
// Multi-cycle left shifter: shifts A left by B positions, one bit per clock, filling with shift_bit.
// Shift amounts of WIDTH or more flush the operand completely.
module seq_left_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             shift_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  localparam int unsigned    CntW     = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
  localparam logic [CntW-1:0]  CntFull  = CntW'(WIDTH);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [CntW-1:0]  CntZero  = '0;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   load_count;
  logic [WIDTH-1:0]  data_q;
  logic              carry_q;
  logic              fill_q;

  // Any amount at or beyond WIDTH saturates to a full flush.
  always_comb begin
    load_count = CntW'(B);
    if (B >= WidthVal) begin
      load_count = CntFull;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= CntZero;
      data_q  <= '0;
      carry_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            data_q  <= A;
            fill_q  <= shift_bit;
            count_q <= load_count;
            carry_q <= 1'b0;
            state_q <= (load_count == CntZero) ? StDone : StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          data_q  <= {data_q[WIDTH-2:0], fill_q};
          carry_q <= data_q[WIDTH-1];
          count_q <= count_q - CntOne;
          if (count_q == CntOne) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StShift);
  assign done      = (state_q == StDone);
  assign data_out  = data_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_left_shifter.sv
// Scoreboard bench for seq_left_shifter: each issued shift pushes its expected result and done cycle.
module tb_seq_left_shifter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         shift_bit;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic         carry_out;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int           n;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  seq_left_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a_in),
    .B         (b_in),
    .shift_bit (shift_bit),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request in the current cycle and record what it must produce.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
    exp_t         e;
    logic [W-1:0] d;
    logic         c;
    int           n;
    n = (int'(b) < W) ? int'(b) : W;
    d = a;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = d[W-1];
      d = {d[W-2:0], sb};
    end
    e.data  = d;
    e.carry = c;
    e.n     = n;
    e.cyc   = cyc + n + 1;
    sb_q.push_back(e);
    start     = 1'b1;
    a_in      = a;
    b_in      = b;
    shift_bit = sb;
    step();
    start     = 1'b0;
    a_in      = W'($urandom);
    b_in      = W'($urandom);
    shift_bit = 1'($urandom);
  endtask

  task automatic wait_drained();
    int budget = 100;
    while (sb_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 0, 1);
  endtask

  // Compare busy/done every cycle against the scoreboard head; pop on done.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      logic exp_done;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (sb_q.size() != 0) begin
        exp_busy = (cyc >= sb_q[0].cyc - sb_q[0].n) && (cyc < sb_q[0].cyc);
        exp_done = (cyc == sb_q[0].cyc);
      end
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        exp_t e;
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("carry_out", 32'(carry_out), 32'(e.carry));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    shift_bit = 1'b0;
    step();
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_carry", 32'(carry_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    step();

    issue(4'b1011, 4'd1, 1'b0);
    wait_drained();
    step();
    issue(4'b1011, 4'd3, 1'b0);
    wait_drained();
    step();
    issue(4'b1011, 4'd3, 1'b1);
    wait_drained();
    step();
    issue(4'b1011, 4'd0, 1'b0);
    wait_drained();
    step();
    issue(4'b1011, 4'd9, 1'b0);
    wait_drained();
    check("idle_hold_data", 32'(data_out), 32'h0);
    check("idle_hold_carry", 32'(carry_out), 32'h1);
    step();

    // Start while busy must be ignored.
    issue(4'b0001, 4'd2, 1'b0);
    start = 1'b1;
    a_in  = 4'b1111;
    b_in  = 4'd1;
    step();
    start = 1'b0;
    wait_drained();
    step();

    // Back-to-back: second request lands in the done cycle of the first.
    issue(4'b1011, 4'd2, 1'b1);
    while (cyc < sb_q[sb_q.size()-1].cyc) step();
    issue(4'b0011, 4'd1, 1'b0);
    wait_drained();
    step();

    // Reset mid-shift aborts with no done pulse.
    issue(4'b1011, 4'd3, 1'b0);
    step();
    rst = 1'b1;
    step();
    sb_q.delete();
    rst = 1'b0;
    check("abort_data", 32'(data_out), 32'h0);
    check("abort_carry", 32'(carry_out), 32'h0);
    repeat (5) step();

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 4'b1111;
    b_in  = 4'd2;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'h0);
    check("rst_prio_data", 32'(data_out), 32'h0);
    repeat (3) step();

    for (int i = 0; i < 12; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_drained();
      end else begin
        while (cyc < sb_q[sb_q.size()-1].cyc) step();
      end
    end
    wait_drained();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
